riscv_div: RTL and testbench

Iterative 32-bit integer divider for the rv32im core, executing the M-extension DIV, DIVU, REM and REMU operations. It sits beside the single-cycle ALU in the execute stage. The pipeline issues an operation through a valid/ready handshake and stalls until a one-cycle result strobe returns.
- Restoring algorithm: one quotient bit per clock.
- Fixed latency, independent of operand values.

---
 rtl/riscv_div_pkg.sv | 27 ++
 rtl/riscv_div.sv | 106 ++++++++++
 tb/tb_riscv_div.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_div_pkg.sv
// Shared definitions for the rv32im iterative divider: operation encodings,
// FSM states and the operand magnitude helper.
package riscv_div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    localparam int unsigned DIV_WIDTH = 32;
    localparam logic [4:0]  LAST_ITER = 5'd31;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, which
    // is the correct value once it is read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] value);
        return value[31] ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/riscv_div.sv
// Restoring 32-bit divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// fixed 33-cycle latency from accept to the result strobe.
module riscv_div
    import riscv_div_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    div_state_t  state;
    logic [31:0] dvd;       // dividend shifts out the top, quotient shifts in the bottom
    logic [31:0] dsr;
    logic [31:0] rem;
    logic [4:0]  count;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;

    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        op_signed;

    // rem < divisor always holds, so the shifted partial remainder needs a
    // 33rd bit when the divisor is at or above 2^31.
    always_comb begin
        rem_shift = {rem, dvd[31]};
        diff      = rem_shift - {1'b0, dsr};
        // A zero divisor yields all-ones regardless of sign, so no negation.
        quo_fix   = (neg_q && (dsr != '0)) ? (~dvd + 32'd1) : dvd;
        rem_fix   = neg_r ? (~rem + 32'd1) : rem;
        op_signed = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
    end

    assign ready_o = (state == ST_IDLE);
    assign busy_o  = ~ready_o;

    // NOTE: every register here is state, so all updates use <= to keep
    // same-edge reads seeing the pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            count    <= '0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_i && !flush_i) begin
                        dvd    <= op_signed ? abs32(dividend_i) : dividend_i;
                        dsr    <= op_signed ? abs32(divisor_i) : divisor_i;
                        neg_q  <= op_signed && (dividend_i[31] ^ divisor_i[31]);
                        neg_r  <= op_signed && dividend_i[31];
                        is_rem <= op_i[1];
                        rem    <= '0;
                        count  <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        state <= ST_IDLE;
                    end else begin
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            dvd <= {dvd[30:0], 1'b1};
                        end else begin
                            rem <= rem_shift[31:0];
                            dvd <= {dvd[30:0], 1'b0};
                        end
                        count <= count + 5'd1;
                        if (count == LAST_ITER) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!flush_i) begin
                        result_o <= is_rem ? rem_fix : quo_fix;
                        valid_o  <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div.sv
// Directed bench for riscv_div: hand-computed results, latency, busy/ready,
// flush, back-to-back issue and asynchronous reset.
module tb_riscv_div;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    riscv_div dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one op at the next negedge, scramble the operands after accept,
    // then wait (bounded) for the strobe and check latency, busy and result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected);
        int  cycles;
        bit  busy_ok;
        @(negedge clk_i);
        check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        valid_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk_i);
        #1;
        valid_i    = 1'b0;
        op_i       = ~op;
        dividend_i = ~a;
        divisor_i  = b ^ 32'h5A5A_0001;
        cycles  = 0;
        busy_ok = 1'b1;
        while (!valid_o && cycles < 40) begin
            if (!busy_o) busy_ok = 1'b0;
            @(posedge clk_i);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, cycles, 32'd33);
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_result"}, result_o, expected);
    endtask

    initial begin
        int          seen;
        logic [31:0] held;

        rst_i      = 1'b1;
        valid_i    = 1'b0;
        op_i       = OP_DIV;
        dividend_i = '0;
        divisor_i  = '0;
        flush_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("div_by0", OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op("divu_by0", OP_DIVU, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_m7_by0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1);
        run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
        // Back-to-back: each run_op call after the previous returns issues in
        // that op's strobe cycle, and ready_o is checked there.
        run_op("b2b_second", OP_DIVU, 32'd1000, 32'd10, 32'd100);

        // Flush at iteration 10: no strobe, result held, ready next cycle.
        held = result_o;
        @(negedge clk_i);
        valid_i    = 1'b1;
        op_i       = OP_DIVU;
        dividend_i = 32'd999;
        divisor_i  = 32'd3;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_ready", {31'd0, ready_o}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        check("flush_no_strobe", seen, 32'd0);
        check("flush_result_held", result_o, held);

        // Flush in IDLE blocks the accept.
        @(negedge clk_i);
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = OP_DIVU;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("idle_flush_blocks", {31'd0, ready_o}, 32'd1);

        // Flush in DONE suppresses the strobe.
        @(negedge clk_i);
        valid_i    = 1'b1;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (32) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("done_flush_strobe", {31'd0, valid_o}, 32'd0);
        check("done_flush_result", result_o, held);

        run_op("after_flush", OP_REMU, 32'd50, 32'd7, 32'd1);

        // Asynchronous reset mid-RUN.
        @(negedge clk_i);
        valid_i    = 1'b1;
        op_i       = OP_DIV;
        dividend_i = 32'd77;
        divisor_i  = 32'd7;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_ready", {31'd0, ready_o}, 32'd1);
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("post_reset", OP_DIV, 32'd77, 32'd7, 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
